spi_master_engine: RTL and testbench

// - SPI shift engine behind each APB3 SPI slot of the SPI router: consumes words the APB register file pushes, drives SCK/MOSI/CS, samples MISO.
// - Returns each received word to the register file and flags frame completion for the interrupt line.
// - Programmable clock divider, CPOL/CPHA (modes 0-3), MSB/LSB first, multi-word frames under one CS.

---
 rtl/spi_master_engine.sv | 187 ++++++++++++++++++
 tb/tb_spi_master_engine.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_engine.sv
`default_nettype none
`timescale 1ns/1ps
// spi_master_engine: SPI shift engine (CPOL/CPHA, divider, MSB/LSB first, multi-word frames). Rev 1.0
// Optional build macro SPI_LOOPBACK_EN adds cfg_loopback (sample internal MOSI instead of SPI_MISO).
module spi_master_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  io_apb_PCLK,
  input  logic                  io_apb_PRESETn,
  input  logic                  cfg_cpol,
  input  logic                  cfg_cpha,
  input  logic                  cfg_lsb_first,
  input  logic [DIV_WIDTH-1:0]  cfg_clk_div,
`ifdef SPI_LOOPBACK_EN
  input  logic                  cfg_loopback,
`endif
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_last,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  SPI_SCK,
  output logic                  SPI_MOSI,
  input  logic                  SPI_MISO,
  output logic                  SPI_CS
);

  localparam int            EW        = $clog2(2*DATA_WIDTH+1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2*DATA_WIDTH);
  localparam logic [EW-1:0] FIRST_EDGE = EW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4,
    S_RECOV = 3'd5
  } state_t;

  state_t                state_q;
  logic [DIV_WIDTH-1:0]  cnt_q, div_q;
  logic [DATA_WIDTH-1:0] tx_sh_q, rx_sh_q, rx_data_q;
  logic [EW-1:0]         edge_q;
  logic cpol_q, cpha_q, lsb_q, last_q;
  logic sck_q, mosi_q, cs_q, busy_q, rx_valid_q, done_q;

  logic                  tick, accept, sample_bit, edge_odd, do_sample, do_shift;
  logic                  first_bit, mosi_d;
  logic [EW-1:0]         edge_d;
  logic [DATA_WIDTH-1:0] rx_sh_d, tx_sh_d;

  assign tick     = (cnt_q == '0);
  assign tx_ready = (state_q == S_IDLE) || (state_q == S_WAIT);
  assign accept   = tx_valid && tx_ready;
  assign edge_d   = edge_q + 1'b1;
  assign edge_odd = edge_d[0];

  // CPHA=0 samples odd edges, CPHA=1 even edges; the first CPHA=1 leading edge keeps the SETUP bit.
  assign do_sample = (state_q == S_XFER) && tick && (edge_odd ^ cpha_q);
  assign do_shift  = (state_q == S_XFER) && tick &&
                     (cpha_q ? (edge_odd && (edge_d != FIRST_EDGE))
                             : (!edge_odd && (edge_d != LAST_EDGE)));

`ifdef SPI_LOOPBACK_EN
  assign sample_bit = cfg_loopback ? mosi_q : SPI_MISO;
`else
  assign sample_bit = SPI_MISO;
`endif

  assign rx_sh_d   = lsb_q ? {sample_bit, rx_sh_q[DATA_WIDTH-1:1]}
                           : {rx_sh_q[DATA_WIDTH-2:0], sample_bit};
  assign tx_sh_d   = lsb_q ? {1'b0, tx_sh_q[DATA_WIDTH-1:1]}
                           : {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
  assign mosi_d    = lsb_q ? tx_sh_d[0] : tx_sh_d[DATA_WIDTH-1];
  assign first_bit = ((state_q == S_IDLE) ? cfg_lsb_first : lsb_q) ? tx_data[0]
                                                                   : tx_data[DATA_WIDTH-1];

  always_ff @(posedge io_apb_PCLK or negedge io_apb_PRESETn) begin
    if (!io_apb_PRESETn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      edge_q     <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      last_q     <= 1'b0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_q       <= 1'b1;
      busy_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= tick ? div_q : cnt_q - 1'b1;
      case (state_q)
        S_IDLE: begin
          sck_q <= cfg_cpol;
          if (accept) begin
            cpol_q  <= cfg_cpol;
            cpha_q  <= cfg_cpha;
            lsb_q   <= cfg_lsb_first;
            div_q   <= cfg_clk_div;
            cnt_q   <= cfg_clk_div;
            tx_sh_q <= tx_data;
            last_q  <= tx_last;
            mosi_q  <= first_bit;
            edge_q  <= '0;
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tick) state_q <= S_XFER;
        end
        S_XFER: begin
          if (tick) begin
            sck_q  <= ~sck_q;
            edge_q <= edge_d;
            if (do_sample) rx_sh_q <= rx_sh_d;
            if (do_shift) begin
              tx_sh_q <= tx_sh_d;
              mosi_q  <= mosi_d;
            end
            if (edge_d == LAST_EDGE) begin
              // With CPHA=1 the final sample lands on this same edge.
              rx_data_q  <= cpha_q ? rx_sh_d : rx_sh_q;
              rx_valid_q <= 1'b1;
              state_q    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          sck_q <= cpol_q;
          if (tick) begin
            if (last_q) begin
              cs_q    <= 1'b1;
              state_q <= S_RECOV;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (accept) begin
            tx_sh_q <= tx_data;
            last_q  <= tx_last;
            mosi_q  <= first_bit;
            edge_q  <= '0;
            cnt_q   <= div_q;
            state_q <= S_SETUP;
          end
        end
        S_RECOV: begin
          if (tick) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            mosi_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign SPI_SCK  = sck_q;
  assign SPI_MOSI = mosi_q;
  assign SPI_CS   = cs_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_engine.sv
`default_nettype none
`timescale 1ns/1ps
// tb_spi_master_engine: directed self-checking bench with a behavioural SPI slave.
module tb_spi_master_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb_first = 1'b0;
  logic [15:0] cfg_clk_div = 16'd1;
`ifdef SPI_LOOPBACK_EN
  logic        cfg_loopback = 1'b0;
`endif
  logic        tx_valid = 1'b0, tx_last = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_ready, rx_valid, busy, done, SPI_SCK, SPI_MOSI, SPI_CS;
  logic [7:0]  rx_data;
  logic        SPI_MISO = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_master_engine #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .io_apb_PCLK   (clk),
    .io_apb_PRESETn(rst_n),
    .cfg_cpol      (cfg_cpol),
    .cfg_cpha      (cfg_cpha),
    .cfg_lsb_first (cfg_lsb_first),
    .cfg_clk_div   (cfg_clk_div),
`ifdef SPI_LOOPBACK_EN
    .cfg_loopback  (cfg_loopback),
`endif
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .tx_last       (tx_last),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .busy          (busy),
    .done          (done),
    .SPI_SCK       (SPI_SCK),
    .SPI_MOSI      (SPI_MOSI),
    .SPI_MISO      (SPI_MISO),
    .SPI_CS        (SPI_CS)
  );

  // ---------------- slave model: MOSI capture + MISO drive ----------------
  logic [7:0] s_words [2];
  logic       s_lsb = 1'b0, s_cpha = 1'b0;
  logic [7:0] cap = 8'h00;
  int         s_edge = 0, s_idx = 0, s_wsel = 0;
  logic       s_cs_prev = 1'b1, s_sck_prev = 1'b0;

  function automatic logic sbit(input int w, input int i);
    logic [7:0] x;
    x = s_words[w];
    return s_lsb ? x[i] : x[7-i];
  endfunction

  always @(SPI_CS or SPI_SCK) begin
    if (s_cs_prev === 1'b1 && SPI_CS === 1'b0) begin
      s_edge = 0; s_idx = 0; s_wsel = 0; cap = 8'h00;
      SPI_MISO = sbit(0, 0);
    end else if (SPI_CS === 1'b0 && SPI_SCK !== s_sck_prev) begin
      s_edge++;
      if ((s_edge % 2 == 1) ^ s_cpha) cap = {cap[6:0], SPI_MOSI};
      if (s_cpha ? (s_edge % 2 == 1 && s_edge > 1) : (s_edge % 2 == 0 && s_edge < 16)) begin
        s_idx++;
        SPI_MISO = sbit(s_wsel, s_idx);
      end
      if (s_edge == 16) begin
        s_edge = 0; s_idx = 0; s_wsel = 1;
        SPI_MISO = sbit(1, 0);
      end
    end
    s_cs_prev  = SPI_CS;
    s_sck_prev = SPI_SCK;
  end

  // ---------------- cycle monitor ----------------
  int   cyc = 0, cs_low = 0, rxv_cnt = 0, done_cnt = 0, acc_cnt = 0, cs_rise = 0, sck_edges = 0;
  int   rise_t[$];
  logic m_sck = 1'b0, m_cs = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (!SPI_CS) cs_low++;
    if (rx_valid) rxv_cnt++;
    if (done) done_cnt++;
    if (tx_valid && tx_ready) acc_cnt++;
    if (SPI_CS && !m_cs) cs_rise++;
    if (SPI_SCK != m_sck) sck_edges++;
    if (SPI_SCK && !m_sck) rise_t.push_back(cyc);
    m_sck = SPI_SCK;
    m_cs  = SPI_CS;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = d; tx_last = l;
    while (!tx_ready && n < 2000) begin @(posedge clk); #1; n++; end
    check("tx_accept_timeout", 32'(n < 2000), 32'd1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 5000) begin @(negedge clk); n++; end
    check("done_timeout", 32'(n < 5000), 32'd1);
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic wait_rxv();
    int n = 0;
    @(negedge clk);
    while (!rx_valid && n < 5000) begin @(negedge clk); n++; end
    check("rxv_timeout", 32'(n < 5000), 32'd1);
  endtask

  task automatic check_period(input string tag, input int from, input int per);
    int bad = 0;
    for (int i = from; i + 1 < rise_t.size(); i++)
      if (rise_t[i+1] - rise_t[i] != per) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  int b_cs, b_rxv, b_done, b_acc, b_rise, b_csr, b_edges;

  task automatic snap();
    b_cs = cs_low; b_rxv = rxv_cnt; b_done = done_cnt; b_acc = acc_cnt;
    b_rise = rise_t.size(); b_csr = cs_rise; b_edges = sck_edges;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    s_words[0] = 8'h00; s_words[1] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_cs",       32'(SPI_CS),   32'd1);
    check("rst_sck",      32'(SPI_SCK),  32'd0);
    check("rst_mosi",     32'(SPI_MOSI), 32'd0);
    check("rst_rx_data",  32'(rx_data),  32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);

    // Mode 0, div 1, MSB first, 0xA5; slave answers 0x3C
    cfg_cpol = 0; cfg_cpha = 0; cfg_lsb_first = 0; cfg_clk_div = 16'd1;
    s_cpha = 0; s_lsb = 0; s_words[0] = 8'h3C;
    settle(); snap();
    send(8'hA5, 1'b1);
    wait_done();
    settle();
    check("m0_mosi_bits",  32'(cap),                     32'hA5);
    check("m0_rx_data",    32'(rx_data),                 32'h3C);
    check("m0_sck_pulses", 32'(rise_t.size() - b_rise),  32'd8);
    check_period("m0_sck_period", b_rise, 4);
    check("m0_cs_low",     32'(cs_low - b_cs),           32'd36);
    check("m0_rxv_pulses", 32'(rxv_cnt - b_rxv),         32'd1);
    check("m0_done_pulses",32'(done_cnt - b_done),       32'd1);

    // Mode 3, div 0, LSB first, 0x01; slave answers 0x80 LSB first
    cfg_cpol = 1; cfg_cpha = 1; cfg_lsb_first = 1; cfg_clk_div = 16'd0;
    s_cpha = 1; s_lsb = 1; s_words[0] = 8'h80;
    settle(); settle();
    check("m3_sck_idle_high", 32'(SPI_SCK), 32'd1);
    snap();
    send(8'h01, 1'b1);
    wait_done();
    settle();
    check("m3_mosi_bits",  32'(cap),                    32'h80);
    check("m3_rx_data",    32'(rx_data),                32'h80);
    check("m3_cs_low",     32'(cs_low - b_cs),          32'd18);
    check("m3_sck_pulses", 32'(rise_t.size() - b_rise), 32'd8);
    check_period("m3_sck_period", b_rise, 2);

    // Two-word frame under one CS, mode 0 div 1 MSB first
    cfg_cpol = 0; cfg_cpha = 0; cfg_lsb_first = 0; cfg_clk_div = 16'd1;
    s_cpha = 0; s_lsb = 0; s_words[0] = 8'hC3; s_words[1] = 8'h5A;
    settle(); settle(); snap();
    send(8'h11, 1'b0);
    wait_rxv();
    check("mw_rx_data0",    32'(rx_data),  32'hC3);
    check("mw_mosi_word0",  32'(cap),      32'h11);
    check("mw_ready_hold",  32'(tx_ready), 32'd0);
    repeat (5) @(negedge clk);
    #1;
    check("mw_ready_wait",  32'(tx_ready), 32'd1);
    check("mw_cs_wait",     32'(SPI_CS),   32'd0);
    send(8'h22, 1'b1);
    wait_done();
    settle();
    check("mw_rx_data1",    32'(rx_data),              32'h5A);
    check("mw_mosi_word1",  32'(cap),                  32'h22);
    check("mw_rxv_pulses",  32'(rxv_cnt - b_rxv),      32'd2);
    check("mw_done_pulses", 32'(done_cnt - b_done),    32'd1);
    check("mw_cs_releases", 32'(cs_rise - b_csr),      32'd1);

    // Mode 1 abort by reset on the 4th SCK edge, then a clean 0xF0 transfer
    cfg_cpol = 0; cfg_cpha = 1; cfg_lsb_first = 0; cfg_clk_div = 16'd2;
    s_cpha = 1; s_lsb = 0; s_words[0] = 8'h0F;
    settle(); settle(); snap();
    send(8'h96, 1'b1);
    begin
      int n = 0;
      while (sck_edges - b_edges < 4 && n < 500) begin settle(); n++; end
      check("abort_edge_timeout", 32'(n < 500), 32'd1);
    end
    rst_n = 1'b0;
    snap();
    settle();
    check("abort_cs",   32'(SPI_CS),   32'd1);
    check("abort_sck",  32'(SPI_SCK),  32'd0);
    check("abort_mosi", 32'(SPI_MOSI), 32'd0);
    check("abort_busy", 32'(busy),     32'd0);
    repeat (3) settle();
    check("abort_no_rxv",  32'(rxv_cnt - b_rxv),   32'd0);
    check("abort_no_done", 32'(done_cnt - b_done), 32'd0);
    rst_n = 1'b1;
    settle(); snap();
    send(8'hF0, 1'b1);
    wait_done();
    settle();
    check("post_mosi_bits", 32'(cap),                 32'hF0);
    check("post_rx_data",   32'(rx_data),             32'h0F);
    check("post_done",      32'(done_cnt - b_done),   32'd1);
    check_period("post_sck_period", b_rise, 6);

    // Config change and held tx_valid during XFER must not disturb the word
    cfg_cpol = 0; cfg_cpha = 0; cfg_lsb_first = 0; cfg_clk_div = 16'd1;
    s_cpha = 0; s_lsb = 0; s_words[0] = 8'hA5;
    settle(); snap();
    send(8'h3C, 1'b1);
    tx_valid = 1'b1; tx_data = 8'hFF; tx_last = 1'b1;
    repeat (10) settle();
    cfg_cpha = 1'b1;
    wait_rxv();
    tx_valid = 1'b0;
    wait_done();
    settle();
    cfg_cpha = 1'b0;
    check("cfgchg_mosi_bits",  32'(cap),                    32'h3C);
    check("cfgchg_rx_data",    32'(rx_data),                32'hA5);
    check("cfgchg_accepts",    32'(acc_cnt - b_acc),        32'd1);
    check("cfgchg_cs_low",     32'(cs_low - b_cs),          32'd36);
    check_period("cfgchg_sck_period", b_rise, 4);

`ifdef SPI_LOOPBACK_EN
    cfg_loopback = 1'b1;
    s_words[0] = 8'h00;
    settle(); snap();
    send(8'h5A, 1'b1);
    wait_done();
    settle();
    check("loop_rx_data", 32'(rx_data), 32'h5A);
    check("loop_mosi",    32'(cap),     32'h5A);
    cfg_loopback = 1'b0;
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
